// File: rtl/ctl_decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, registered instruction decoder and
// general-purpose register file for the multicycle RV32I core.
// Optional build macro RV32E_EN: 16-entry register file; a used register
// field with bit 4 set is flagged illegal, and reads of such an index return 0.
module ctl_decode_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [31:0] instr,
    input  logic [31:0] wb_data,
    output logic [1:0]  state,
    output logic        fetch_en,
    output logic        pc_inc,
    output logic [3:0]  op_class,
    output logic [2:0]  funct3,
    output logic        funct7_b5,
    output logic [4:0]  rd_idx,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    output logic [31:0] imm,
    output logic        regfile_we,
    output logic        illegal,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OC_LUI      = 4'd0,
        OC_AUIPC    = 4'd1,
        OC_JAL      = 4'd2,
        OC_JALR     = 4'd3,
        OC_BRANCH   = 4'd4,
        OC_LOAD     = 4'd5,
        OC_STORE    = 4'd6,
        OC_OP_IMM   = 4'd7,
        OC_OP       = 4'd8,
        OC_MISC_MEM = 4'd9,
        OC_SYSTEM   = 4'd10,
        OC_ILLEGAL  = 4'd15
    } op_class_t;

`ifdef RV32E_EN
    localparam int unsigned NREG = 16;
    localparam int unsigned AW   = 4;
`else
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
`endif

    state_t      cur_state, nxt_state;
    op_class_t   base_class, d_class, class_q;
    logic [31:0] base_imm, d_imm, imm_q;
    logic        base_we, d_we, we_q;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0]  funct3_q;
    logic        f7b5_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [31:0] regs [NREG];
    logic [31:0] wr_data;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   cur_state <= S_FETCH;
        else if (ce) cur_state <= nxt_state;
    end

    // Next-state: fixed four-step cycle
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:     nxt_state = S_DECODE;
            S_DECODE:    nxt_state = S_EXECUTE;
            S_EXECUTE:   nxt_state = S_WRITEBACK;
            S_WRITEBACK: nxt_state = S_FETCH;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // Moore outputs
    always_comb begin
        fetch_en = 1'b0;
        pc_inc   = 1'b0;
        if (cur_state == S_FETCH) begin
            fetch_en = 1'b1;
            pc_inc   = 1'b1;
        end
    end

    // Opcode decode: class, immediate format and write enable
    always_comb begin
        base_class = OC_ILLEGAL;
        base_imm   = '0;
        base_we    = 1'b0;
        case (instr[6:0])
            7'b0110111: begin base_class = OC_LUI;      base_imm = imm_u; base_we = 1'b1; end
            7'b0010111: begin base_class = OC_AUIPC;    base_imm = imm_u; base_we = 1'b1; end
            7'b1101111: begin base_class = OC_JAL;      base_imm = imm_j; base_we = 1'b1; end
            7'b1100111: begin base_class = OC_JALR;     base_imm = imm_i; base_we = 1'b1; end
            7'b1100011: begin base_class = OC_BRANCH;   base_imm = imm_b; end
            7'b0000011: begin base_class = OC_LOAD;     base_imm = imm_i; base_we = 1'b1; end
            7'b0100011: begin base_class = OC_STORE;    base_imm = imm_s; end
            7'b0010011: begin base_class = OC_OP_IMM;   base_imm = imm_i; base_we = 1'b1; end
            7'b0110011: begin base_class = OC_OP;       base_we = 1'b1; end
            7'b0001111: begin base_class = OC_MISC_MEM; base_imm = imm_i; end
            7'b1110011: begin base_class = OC_SYSTEM;   base_imm = imm_i; end
            default:    ;
        endcase
    end

`ifdef RV32E_EN
    logic bad_idx;

    // Flag any register field the format actually uses that points above x15
    always_comb begin
        bad_idx = 1'b0;
        case (base_class)
            OC_LUI, OC_AUIPC, OC_JAL:
                bad_idx = instr[11];
            OC_JALR, OC_LOAD, OC_OP_IMM, OC_MISC_MEM, OC_SYSTEM:
                bad_idx = instr[11] | instr[19];
            OC_BRANCH, OC_STORE:
                bad_idx = instr[19] | instr[24];
            OC_OP:
                bad_idx = instr[11] | instr[19] | instr[24];
            default:
                bad_idx = 1'b0;
        endcase
    end

    assign d_class = bad_idx ? OC_ILLEGAL : base_class;
    assign d_imm   = bad_idx ? '0 : base_imm;
    assign d_we    = bad_idx ? 1'b0 : base_we;
`else
    assign d_class = base_class;
    assign d_imm   = base_imm;
    assign d_we    = base_we;
`endif

    // Decoder register: capture at the end of DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            class_q  <= OC_LUI;
            imm_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            f7b5_q   <= 1'b0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else if (ce && cur_state == S_DECODE) begin
            class_q  <= d_class;
            imm_q    <= d_imm;
            we_q     <= d_we;
            funct3_q <= instr[14:12];
            f7b5_q   <= instr[30];
            rd_q     <= instr[11:7];
            rs1_q    <= instr[19:15];
            rs2_q    <= instr[24:20];
        end
    end

    assign wr_data = (class_q == OC_LUI) ? imm_q : wb_data;

    // Register file write at the end of WRITEBACK; x0 never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (ce && cur_state == S_WRITEBACK && we_q && rd_q != '0) begin
            regs[rd_q[AW-1:0]] <= wr_data;
        end
    end

`ifdef RV32E_EN
    assign rs1_data = (rs1_q[4] || rs1_q[3:0] == '0) ? '0 : regs[rs1_q[3:0]];
    assign rs2_data = (rs2_q[4] || rs2_q[3:0] == '0) ? '0 : regs[rs2_q[3:0]];
`else
    assign rs1_data = (rs1_q == '0) ? '0 : regs[rs1_q];
    assign rs2_data = (rs2_q == '0) ? '0 : regs[rs2_q];
`endif

    assign state      = cur_state;
    assign op_class   = class_q;
    assign funct3     = funct3_q;
    assign funct7_b5  = f7b5_q;
    assign rd_idx     = rd_q;
    assign rs1_idx    = rs1_q;
    assign rs2_idx    = rs2_q;
    assign imm        = imm_q;
    assign regfile_we = we_q;
    assign illegal    = (class_q == OC_ILLEGAL);

endmodule

// File: tb/tb_ctl_decode_regfile.sv
// Directed self-checking bench for ctl_decode_regfile (default build).
module tb_ctl_decode_regfile;

    logic        clk = 1'b0;
    logic        reset, ce;
    logic [31:0] instr, wb_data;
    logic [1:0]  state;
    logic        fetch_en, pc_inc;
    logic [3:0]  op_class;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [31:0] imm;
    logic        regfile_we, illegal;
    logic [31:0] rs1_data, rs2_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ctl_decode_regfile dut (
        .clk(clk), .reset(reset), .ce(ce), .instr(instr), .wb_data(wb_data),
        .state(state), .fetch_en(fetch_en), .pc_inc(pc_inc),
        .op_class(op_class), .funct3(funct3), .funct7_b5(funct7_b5),
        .rd_idx(rd_idx), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .imm(imm),
        .regfile_we(regfile_we), .illegal(illegal),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Run one full instruction from a FETCH negedge to the next FETCH negedge
    task automatic run_instr(input logic [31:0] i, input logic [31:0] w);
        instr   = i;
        wb_data = w;
        repeat (4) @(negedge clk);
    endtask

    // Read two registers through a harmless "add x0, ra, rb"
    task automatic readback(input string tag, input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] ea, input logic [31:0] eb);
        run_instr({7'b0, b, a, 3'b000, 5'd0, 7'b0110011}, 32'h0BAD_F00D);
        check({tag, ".state"}, state, 0);
        check({tag, ".rs1"}, rs1_data, ea);
        check({tag, ".rs2"}, rs2_data, eb);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; instr = '0; wb_data = '0;
        repeat (2) @(negedge clk);
        check("rst.state", state, 0);
        check("rst.fetch_en", fetch_en, 1);
        check("rst.pc_inc", pc_inc, 1);
        check("rst.op_class", op_class, 0);
        check("rst.imm", imm, 0);
        check("rst.we", regfile_we, 0);
        check("rst.illegal", illegal, 0);
        reset = 1'b0;

        // addi x1,x0,5
        run_instr(32'h0050_0093, 32'd5);
        check("addi.op_class", op_class, 7);
        check("addi.rd", rd_idx, 1);
        check("addi.rs1", rs1_idx, 0);
        check("addi.imm", imm, 5);
        check("addi.we", regfile_we, 1);
        check("addi.illegal", illegal, 0);
        readback("addi.rb", 5'd1, 5'd0, 32'd5, 32'd0);

        // lui x5,0x12345 -- write data must ignore wb_data
        run_instr(32'h1234_52B7, 32'hDEAD_BEEF);
        check("lui.op_class", op_class, 0);
        check("lui.imm", imm, 32'h1234_5000);
        check("lui.rd", rd_idx, 5);
        check("lui.we", regfile_we, 1);
        readback("lui.rb", 5'd5, 5'd1, 32'h1234_5000, 32'd5);

        // beq x1,x2,-4: no write, operands read from decoded indices
        run_instr(32'hFE20_8EE3, 32'h0000_AAAA);
        check("beq.op_class", op_class, 4);
        check("beq.imm", imm, 32'hFFFF_FFFC);
        check("beq.rs1", rs1_idx, 1);
        check("beq.rs2", rs2_idx, 2);
        check("beq.we", regfile_we, 0);
        check("beq.funct3", funct3, 0);
        check("beq.f7b5", funct7_b5, 1);
        check("beq.rs1_data", rs1_data, 32'd5);
        check("beq.rs2_data", rs2_data, 32'd0);
        readback("beq.rb", 5'd1, 5'd29, 32'd5, 32'd0);

        // sw x2,8(x1): S-format immediate, no write
        run_instr(32'h0020_A423, 32'h0000_5555);
        check("sw.op_class", op_class, 6);
        check("sw.imm", imm, 32'd8);
        check("sw.we", regfile_we, 0);
        check("sw.funct3", funct3, 2);
        readback("sw.rb", 5'd8, 5'd5, 32'd0, 32'h1234_5000);

        // jal x1,8: J-format immediate, link value from wb_data
        run_instr(32'h0080_00EF, 32'h0000_0100);
        check("jal.op_class", op_class, 2);
        check("jal.imm", imm, 32'd8);
        check("jal.we", regfile_we, 1);
        readback("jal.rb", 5'd1, 5'd5, 32'h0000_0100, 32'h1234_5000);

        // all-ones word: illegal, no write to x31
        run_instr(32'hFFFF_FFFF, 32'h1111_2222);
        check("ill.illegal", illegal, 1);
        check("ill.op_class", op_class, 15);
        check("ill.we", regfile_we, 0);
        check("ill.imm", imm, 0);
        readback("ill.rb", 5'd31, 5'd1, 32'd0, 32'h0000_0100);

        // addi x0,x0,10: x0 stays zero
        run_instr(32'h00A0_0013, 32'd10);
        check("x0.imm", imm, 10);
        check("x0.rd", rd_idx, 0);
        readback("x0.rb", 5'd0, 5'd1, 32'd0, 32'h0000_0100);

        // clock-enable freeze in EXECUTE during addi x3,x0,7
        instr = 32'h0070_0193; wb_data = 32'd7;
        repeat (2) @(negedge clk);
        check("ce.pre_state", state, 2);
        ce = 1'b0; instr = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("ce.state", state, 2);
        check("ce.fetch_en", fetch_en, 0);
        check("ce.op_class", op_class, 7);
        check("ce.imm", imm, 7);
        check("ce.rd", rd_idx, 3);
        ce = 1'b1;
        @(negedge clk);
        check("ce.wb_state", state, 3);
        @(negedge clk);
        check("ce.resume_state", state, 0);
        check("ce.resume_fetch", fetch_en, 1);
        readback("ce.rb", 5'd3, 5'd1, 32'd7, 32'h0000_0100);

        // asynchronous reset in the middle of EXECUTE of lui x6
        instr = 32'h1234_5337; wb_data = 32'h7777_7777;
        repeat (2) @(negedge clk);
        check("mid.pre_state", state, 2);
        check("mid.pre_imm", imm, 32'h1234_5000);
        reset = 1'b1;
        #1;
        check("mid.state", state, 0);
        check("mid.fetch_en", fetch_en, 1);
        check("mid.pc_inc", pc_inc, 1);
        check("mid.op_class", op_class, 0);
        check("mid.imm", imm, 0);
        check("mid.rd", rd_idx, 0);
        check("mid.we", regfile_we, 0);
        check("mid.illegal", illegal, 0);
        check("mid.rs1_data", rs1_data, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readback($sformatf("clr.x%0d", i), 5'(i), 5'(31 - i), 32'd0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
